bat_charge_ctrl: RTL
====================

BAT_CHARGE_CTRL -- requirements
Module: bat_charge_ctrl

Interface
REQ-001 Parameters (name, default, meaning), one per line:
  ADC_W, 10, width of all voltage/temperature codes
  VCUTOFF, 10'd614, trickle/CC boundary (3.0 V at 5 V full scale)
  VPRESET, 10'd860, CC/CV boundary (4.2 V)
  VRECHG, 10'd819, recharge threshold from DONE (4.0 V)
  TMIN, 10'd100, lowest allowed temperature code
  TMAX, 10'd900, highest allowed temperature code
  DEB, 4, consecutive qualifying samples required for any threshold transition (1..15)
  TIMEOUT, 24'd10_000_000, maximum charging clock cycles before fault
REQ-002 Ports (name, direction, width, meaning), one per line:
  clk, in, 1, single clock for the block
  rst, in, 1, synchronous active-high reset
  en, in, 1, charger enable
  sel, in, 4, capacity select; C = 50 + 50*sel mAh
  sample_valid, in, 1, one-cycle strobe; the three sample inputs are valid this cycle
  vbat_code, in, ADC_W, battery voltage sample
  ibat_ma, in, 10, battery current sample in mA
  vtemp_code, in, ADC_W, battery temperature sample
  tc, out, 1, trickle-current mode active
  cc, out, 1, constant-current mode active
  cv, out, 1, constant-voltage mode active
  done, out, 1, charge complete
  fault, out, 1, temperature or timeout fault latched
  iset_ma, out, 10, current setpoint to the charger datapath in mA

Function
REQ-003 The FSM SHALL have states OFF, TC, CC, CV, DONE and FAULT; tc/cc/cv/done/fault SHALL be one-hot decodes of TC/CC/CV/DONE/FAULT, all 0 in OFF.
REQ-004 All outputs SHALL be registered and SHALL change on the same edge as the state register.
REQ-005 Priority per cycle, highest first: en=0 -> OFF; fault condition -> FAULT; threshold transition; hold.
REQ-006 OFF: on sample_valid with en=1 and temperature in range, SHALL go to TC if vbat_code<VCUTOFF, else CC; sel SHALL be latched into cap_q on this edge.
REQ-007 TC -> CC after DEB consecutive valid samples with vbat_code>=VCUTOFF.
REQ-008 CC -> CV after DEB consecutive valid samples with vbat_code>=VPRESET.
REQ-009 CV -> DONE after DEB consecutive valid samples with ibat_ma < (C>>4).
REQ-010 DONE -> CC after DEB consecutive valid samples with vbat_code<VRECHG (TC instead if the last such sample is <VCUTOFF).
REQ-011 Debounce counter SHALL clear on every state change and on any valid sample failing the current state's condition; non-valid cycles SHALL leave it unchanged; it SHALL saturate at DEB.
REQ-012 Fault condition (TC, CC or CV only): valid sample with vtemp_code<TMIN or >TMAX, or timeout counter reaching TIMEOUT.
REQ-013 FAULT SHALL be sticky until en=0; it SHALL NOT exit on a return to normal temperature.
REQ-014 Timeout counter SHALL clear in OFF and DONE, SHALL count every cycle in TC/CC/CV, SHALL saturate, and SHALL NOT clear on TC->CC->CV transitions.
REQ-015 iset_ma SHALL be C>>3 in TC, C in CC and CV, 0 elsewhere, where C = 50+50*cap_q (10-bit, max 800); sel changes while not in OFF SHALL be ignored.
REQ-016 When en falls and a transition qualifies in the same cycle, OFF SHALL win.

Reset
REQ-017 rst=1 on a clk edge SHALL force OFF, all outputs 0, iset_ma=0, cap_q=0, and debounce and timeout counters to 0, overriding all other inputs.
REQ-018 Reset asserted mid-charge SHALL abandon the charge; after reset release, re-entry SHALL follow REQ-006 only.

Structure
REQ-019 Package bat_charge_pkg SHALL hold the state enum, threshold default constants, and the capacity/current conversion function.
REQ-020 The consecutive-sample counter SHALL be the sub-module charge_debounce (inputs: clear, sample_valid, cond; output: met), instantiated once.

Verification
REQ-021 sel=4'b1000, en=1, vbat=500, temp=500 -> TC, iset_ma=56; after 4 samples at vbat=620 -> CC, iset_ma=450.
REQ-022 In CC, vbat=860 on 3 samples, 1 sample at 859, then 4 at 860 -> CV entered only after the final 4th sample.
REQ-023 In CV, ibat_ma=27 for 4 samples (C=450, end=28) -> DONE, iset_ma=0; vbat=800 for 4 samples -> CC.
REQ-024 In CC, one sample with vtemp=950 -> FAULT next edge; temp back to 500 keeps FAULT; en=0 -> OFF.
REQ-025 TIMEOUT=1000 with vbat held at 700 -> FAULT exactly 1000 cycles after leaving OFF; rst pulse mid-CC -> OFF, all outputs 0 on the next edge.

Source files
------------

// File: rtl/bat_charge_pkg.sv
// Shared types, default thresholds and capacity-to-current conversion for the
// battery charge controller.
package bat_charge_pkg;

   localparam int unsigned DEF_ADC_W   = 10;
   localparam int unsigned DEF_VCUTOFF = 614;
   localparam int unsigned DEF_VPRESET = 860;
   localparam int unsigned DEF_VRECHG  = 819;
   localparam int unsigned DEF_TMIN    = 100;
   localparam int unsigned DEF_TMAX    = 900;
   localparam int unsigned DEF_DEB     = 4;
   localparam int unsigned DEF_TIMEOUT = 10_000_000;

   localparam int unsigned CAP_W = 4;
   localparam int unsigned MA_W  = 10;
   localparam int unsigned TO_W  = 24;
   localparam int unsigned DEB_W = 4;

   typedef enum logic [2:0] {
      ST_OFF   = 3'd0,
      ST_TC    = 3'd1,
      ST_CC    = 3'd2,
      ST_CV    = 3'd3,
      ST_DONE  = 3'd4,
      ST_FAULT = 3'd5
   } state_t;

   // Capacity C = 50 + 50*cap mAh, used directly as the 1C current in mA.
   function automatic logic [MA_W-1:0] cap_to_ma(input logic [CAP_W-1:0] cap);
      return MA_W'(32'd50 + 32'd50 * 32'(cap));
   endfunction

   function automatic logic [MA_W-1:0] iset_for(input state_t st,
                                                input logic [CAP_W-1:0] cap);
      logic [MA_W-1:0] ma;
      ma = cap_to_ma(cap);
      case (st)
         ST_TC:        iset_for = ma >> 3;
         ST_CC, ST_CV: iset_for = ma;
         default:      iset_for = '0;
      endcase
   endfunction

endpackage

// File: rtl/charge_debounce.sv
// Counts consecutive valid samples meeting a condition; met fires on the
// sample that completes the DEB-long run.
module charge_debounce
   import bat_charge_pkg::*;
#(
   parameter int unsigned DEB = DEF_DEB
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic sample_valid,
   input  logic cond,
   output logic met
);

   logic [DEB_W-1:0] cnt_q, cnt_d;

   assign met = sample_valid && cond && (cnt_q >= DEB_W'(DEB - 1));

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (sample_valid) begin
         if (!cond)
            cnt_d = '0;
         else if (cnt_q < DEB_W'(DEB))
            cnt_d = cnt_q + DEB_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (rst)
         cnt_q <= '0;
      else
         cnt_q <= cnt_d;
   end

endmodule

// File: rtl/bat_charge_ctrl.sv
// Li-ion charge controller: trickle / constant-current / constant-voltage
// sequencing with debounced thresholds, temperature and timeout faults.
module bat_charge_ctrl
   import bat_charge_pkg::*;
#(
   parameter int unsigned ADC_W   = DEF_ADC_W,
   parameter int unsigned VCUTOFF = DEF_VCUTOFF,
   parameter int unsigned VPRESET = DEF_VPRESET,
   parameter int unsigned VRECHG  = DEF_VRECHG,
   parameter int unsigned TMIN    = DEF_TMIN,
   parameter int unsigned TMAX    = DEF_TMAX,
   parameter int unsigned DEB     = DEF_DEB,
   parameter int unsigned TIMEOUT = DEF_TIMEOUT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [3:0]       sel,
   input  logic             sample_valid,
   input  logic [ADC_W-1:0] vbat_code,
   input  logic [9:0]       ibat_ma,
   input  logic [ADC_W-1:0] vtemp_code,
   output logic             tc,
   output logic             cc,
   output logic             cv,
   output logic             done,
   output logic             fault,
   output logic [9:0]       iset_ma
);

   state_t           state_q, state_d;
   logic [CAP_W-1:0] cap_q, cap_d;
   logic [TO_W-1:0]  to_q, to_d;
   logic             tc_q, cc_q, cv_q, done_q, fault_q;
   logic [MA_W-1:0]  iset_q;

   logic             temp_ok_c, active_c, fault_c, cond_c, met_c, clear_c;
   logic             below_cut_c;
   logic [MA_W-1:0]  cap_ma_c;

   assign cap_ma_c    = cap_to_ma(cap_q);
   assign below_cut_c = vbat_code < ADC_W'(VCUTOFF);
   assign temp_ok_c   = (vtemp_code >= ADC_W'(TMIN)) && (vtemp_code <= ADC_W'(TMAX));
   assign active_c    = (state_q == ST_TC) || (state_q == ST_CC) || (state_q == ST_CV);
   // Timeout fires on the edge where the charging cycle count reaches TIMEOUT.
   assign fault_c     = active_c && ((sample_valid && !temp_ok_c) ||
                                     (to_q >= TO_W'(TIMEOUT - 1)));

   always_comb begin
      cond_c = 1'b0;
      case (state_q)
         ST_TC:   cond_c = !below_cut_c;
         ST_CC:   cond_c = vbat_code >= ADC_W'(VPRESET);
         ST_CV:   cond_c = ibat_ma < (cap_ma_c >> 4);
         ST_DONE: cond_c = vbat_code < ADC_W'(VRECHG);
         default: cond_c = 1'b0;
      endcase
   end

   assign clear_c = (state_d != state_q);

   charge_debounce #(.DEB(DEB)) u_debounce (
      .clk          (clk),
      .rst          (rst),
      .clear        (clear_c),
      .sample_valid (sample_valid),
      .cond         (cond_c),
      .met          (met_c)
   );

   // Next state: disable beats fault beats threshold transitions beats hold.
   always_comb begin
      state_d = state_q;
      cap_d   = cap_q;
      if (!en) begin
         state_d = ST_OFF;
      end else if (fault_c) begin
         state_d = ST_FAULT;
      end else begin
         case (state_q)
            ST_OFF: begin
               if (sample_valid && temp_ok_c) begin
                  state_d = below_cut_c ? ST_TC : ST_CC;
                  cap_d   = sel;
               end
            end
            ST_TC:   if (met_c) state_d = ST_CC;
            ST_CC:   if (met_c) state_d = ST_CV;
            ST_CV:   if (met_c) state_d = ST_DONE;
            ST_DONE: if (met_c) state_d = below_cut_c ? ST_TC : ST_CC;
            default: state_d = state_q;
         endcase
      end
   end

   always_comb begin
      to_d = to_q;
      case (state_q)
         ST_OFF, ST_DONE:    to_d = '0;
         ST_TC, ST_CC, ST_CV:
            if (to_q < TO_W'(TIMEOUT)) to_d = to_q + TO_W'(1);
         default:            to_d = to_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_OFF;
         cap_q   <= '0;
         to_q    <= '0;
         tc_q    <= 1'b0;
         cc_q    <= 1'b0;
         cv_q    <= 1'b0;
         done_q  <= 1'b0;
         fault_q <= 1'b0;
         iset_q  <= '0;
      end else begin
         state_q <= state_d;
         cap_q   <= cap_d;
         to_q    <= to_d;
         tc_q    <= (state_d == ST_TC);
         cc_q    <= (state_d == ST_CC);
         cv_q    <= (state_d == ST_CV);
         done_q  <= (state_d == ST_DONE);
         fault_q <= (state_d == ST_FAULT);
         iset_q  <= iset_for(state_d, cap_d);
      end
   end

   assign tc      = tc_q;
   assign cc      = cc_q;
   assign cv      = cv_q;
   assign done    = done_q;
   assign fault   = fault_q;
   assign iset_ma = iset_q;

endmodule
